// File: rtl/matmul_pkg.sv
// Shared definitions for the matmul_array slice.
//   state_t  : FSM encoding (IDLE / ACCUM / DRAIN)
//   acc_w    : accumulator/result width for a given operand width and max beat count
//   k_w      : width of the k_len field
//   idx_w    : width of a row/column index for an N-wide array
package matmul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Sum of k_max products of two dw-bit values never exceeds this width.
    function automatic int acc_w(input int dw, input int k_max);
        return (32'sd2 * dw) + $clog2(k_max);
    endfunction

    function automatic int k_w(input int k_max);
        return $clog2(k_max + 32'sd1);
    endfunction

    // An index needs at least one bit even for a 1x1 array.
    function automatic int idx_w(input int n);
        return (n > 32'sd1) ? $clog2(n) : 32'sd1;
    endfunction

endpackage

// File: rtl/matmul_array_if.sv
// Job / beat / result bundle of matmul_array.
//   slave  : the array side (accepts beats, produces results)
//   master : the driver side (issues jobs, supplies beats, sinks results)
// Signals: start, k_len, in_valid, in_ready, w_data, x_data,
//          out_valid, out_ready, out_data, out_row, out_col, out_last, busy.
interface matmul_array_if
    import matmul_pkg::*;
#(
    parameter int N     = 3,
    parameter int DW    = 4,
    parameter int K_MAX = 3
);
    localparam int KW   = k_w(K_MAX);
    localparam int ACCW = acc_w(DW, K_MAX);
    localparam int IW   = idx_w(N);

    logic            start;
    logic [KW-1:0]   k_len;
    logic            in_valid;
    logic            in_ready;
    logic [N*DW-1:0] w_data;
    logic [N*DW-1:0] x_data;
    logic            out_valid;
    logic            out_ready;
    logic [ACCW-1:0] out_data;
    logic [IW-1:0]   out_row;
    logic [IW-1:0]   out_col;
    logic            out_last;
    logic            busy;

    modport slave (
        input  start, k_len, in_valid, w_data, x_data, out_ready,
        output in_ready, out_valid, out_data, out_row, out_col, out_last, busy
    );

    modport master (
        output start, k_len, in_valid, w_data, x_data, out_ready,
        input  in_ready, out_valid, out_data, out_row, out_col, out_last, busy
    );

endinterface

// File: rtl/mac_cell.sv
// One multiply-accumulate cell of the output-stationary grid.
// Ports:
//   clk  : rising-edge clock
//   clr  : synchronous clear of the accumulator (wins over en)
//   en   : add w*x into the accumulator this edge
//   w, x : DW-bit operands
//   acc  : ACCW-bit accumulated value
// Build option: MATMUL_ARRAY_SIGNED_EN selects two's-complement operands
// with a sign-extended product; otherwise unsigned and zero-extended.
module mac_cell
    import matmul_pkg::*;
#(
    parameter int DW   = 4,
    parameter int ACCW = 10
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            en,
    input  logic [DW-1:0]   w,
    input  logic [DW-1:0]   x,
    output logic [ACCW-1:0] acc
);

    logic [ACCW-1:0] acc_r;

`ifdef MATMUL_ARRAY_SIGNED_EN
    logic signed [2*DW-1:0] prod_s;
    logic signed [ACCW-1:0] prod_ext_s;
    // Operands are widened as signed values so the product keeps its sign.
    assign prod_s     = (2*DW)'($signed(w)) * (2*DW)'($signed(x));
    assign prod_ext_s = ACCW'(prod_s);
`else
    logic [2*DW-1:0] prod_s;
    logic [ACCW-1:0] prod_ext_s;
    assign prod_s     = (2*DW)'(w) * (2*DW)'(x);
    assign prod_ext_s = ACCW'(prod_s);
`endif

    // Accumulator register: clear, accumulate, or hold.
    always_ff @(posedge clk) begin
        if (clr) begin
            acc_r <= '0;
        end else if (en) begin
            acc_r <= acc_r + prod_ext_s;
        end else begin
            acc_r <= acc_r;
        end
    end

    assign acc = acc_r;

endmodule

// File: rtl/matmul_array.sv
// NxN output-stationary matrix multiplier, C = W * X with K beats per job.
// Each accepted beat carries column k of W and row k of X; every cell (i,j)
// adds w[i]*x[j]. After the last beat the NxN results stream out row-major.
// Ports:
//   clk   : rising-edge clock
//   clear : synchronous active-high reset, overrides everything
//   bus   : matmul_array_if.slave (job control, beat input, result output)
// Build option: MATMUL_ARRAY_SIGNED_EN (signed operands/results, see mac_cell).
module matmul_array
    import matmul_pkg::*;
#(
    parameter int N     = 3,
    parameter int DW    = 4,
    parameter int K_MAX = 3
) (
    input  logic           clk,
    input  logic           clear,
    matmul_array_if.slave  bus
);

    localparam int KW   = k_w(K_MAX);
    localparam int ACCW = acc_w(DW, K_MAX);
    localparam int IW   = idx_w(N);

    state_t          state_r;
    state_t          state_nx;
    logic [KW-1:0]   k_lat_r;
    logic [KW-1:0]   beat_cnt_r;
    logic [KW-1:0]   k_eff_s;
    logic [IW-1:0]   row_r;
    logic [IW-1:0]   col_r;
    logic            start_s;
    logic            beat_s;
    logic            xfer_s;
    logic            last_s;
    logic            acc_clr_s;
    logic [ACCW-1:0] acc_s [N][N];

    // Requested beat count forced into 1..K_MAX.
    always_comb begin
        k_eff_s = bus.k_len;
        if (bus.k_len == '0) begin
            k_eff_s = KW'(1'b1);
        end else if (bus.k_len > KW'(K_MAX)) begin
            k_eff_s = KW'(K_MAX);
        end else begin
            k_eff_s = bus.k_len;
        end
    end

    // Handshake qualifiers; in_ready/out_valid are pure state decodes.
    always_comb begin
        start_s   = (state_r == ST_IDLE) && bus.start;
        beat_s    = (state_r == ST_ACCUM) && bus.in_valid;
        xfer_s    = (state_r == ST_DRAIN) && bus.out_ready;
        last_s    = (row_r == IW'(N - 1)) && (col_r == IW'(N - 1));
        acc_clr_s = clear || start_s;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) state_nx = ST_ACCUM;
                else           state_nx = ST_IDLE;
            end
            ST_ACCUM: begin
                if (beat_s && (beat_cnt_r == (k_lat_r - KW'(1'b1)))) state_nx = ST_DRAIN;
                else                                                state_nx = ST_ACCUM;
            end
            ST_DRAIN: begin
                if (xfer_s && last_s) state_nx = ST_IDLE;
                else                  state_nx = ST_DRAIN;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (clear) state_r <= ST_IDLE;
        else       state_r <= state_nx;
    end

    // Latched job length and accepted-beat counter.
    always_ff @(posedge clk) begin
        if (clear) begin
            k_lat_r    <= '0;
            beat_cnt_r <= '0;
        end else if (start_s) begin
            k_lat_r    <= k_eff_s;
            beat_cnt_r <= '0;
        end else if (beat_s) begin
            beat_cnt_r <= beat_cnt_r + KW'(1'b1);
        end else begin
            beat_cnt_r <= beat_cnt_r;
        end
    end

    // Row-major drain index; wraps back to (0,0) on the final transfer.
    always_ff @(posedge clk) begin
        if (clear || start_s) begin
            row_r <= '0;
            col_r <= '0;
        end else if (xfer_s) begin
            if (col_r == IW'(N - 1)) begin
                col_r <= '0;
                row_r <= last_s ? '0 : (row_r + IW'(1'b1));
            end else begin
                col_r <= col_r + IW'(1'b1);
            end
        end else begin
            row_r <= row_r;
            col_r <= col_r;
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            mac_cell #(
                .DW   (DW),
                .ACCW (ACCW)
            ) u_mac (
                .clk (clk),
                .clr (acc_clr_s),
                .en  (beat_s),
                .w   (bus.w_data[gi*DW +: DW]),
                .x   (bus.x_data[gj*DW +: DW]),
                .acc (acc_s[gi][gj])
            );
        end
    end

    assign bus.in_ready  = (state_r == ST_ACCUM);
    assign bus.out_valid = (state_r == ST_DRAIN);
    assign bus.busy      = (state_r != ST_IDLE);
    assign bus.out_row   = row_r;
    assign bus.out_col   = col_r;
    assign bus.out_last  = (state_r == ST_DRAIN) && last_s;

    // Result mux; held at zero outside DRAIN so nothing stale is presented.
    always_comb begin
        if (state_r == ST_DRAIN) bus.out_data = acc_s[row_r][col_r];
        else                     bus.out_data = '0;
    end

endmodule
